// File: rtl/max_pool_2x2_stream.sv
// ---------------------------------------------------------------------------
// max_pool_2x2_stream
//
// Streaming 2x2 / stride-2 max-pool stage. Consumes a raster-order frame of
// signed samples (IMG_WIDTH x IMG_HEIGHT) and emits the pooled map
// (IMG_WIDTH/2 x IMG_HEIGHT/2) in raster order. One half-width row buffer
// holds the horizontal pair maxima of each even row until the matching odd
// row arrives. Odd trailing columns/rows are accepted and dropped.
//
// Optional build macro: MAXPOOL_ARGMAX_EN
//   Adds out_idx_o, the winner position inside the 2x2 window
//   (0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right, ties -> lowest).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   frame_start_i  arms a new frame (honoured only when idle)
//   in_valid_i     input sample valid
//   in_ready_o     block accepts a sample this cycle
//   in_data_i      signed input sample
//   out_valid_o    pooled sample valid
//   out_ready_i    downstream accepts the pooled sample
//   out_data_o     signed pooled maximum
//   out_idx_o      window winner index (MAXPOOL_ARGMAX_EN only)
//   out_last_o     final pooled sample of the frame
//   busy_o         frame in progress (RUN or FLUSH)
//   frame_done_o   one-cycle pulse on frame completion
// ---------------------------------------------------------------------------
module max_pool_2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [1:0]            out_idx_o,
`endif
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int POOL_W = IMG_WIDTH / 2;
  localparam int POOL_H = IMG_HEIGHT / 2;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int HW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  localparam logic [CW-1:0] LAST_COL      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW      = RW'(IMG_HEIGHT - 1);
  // Last column/row that belongs to a complete 2x2 window.
  localparam logic [CW-1:0] LAST_PAIR_COL = CW'(2 * POOL_W - 1);
  localparam logic [RW-1:0] LAST_PAIR_ROW = RW'(2 * POOL_H - 1);

  // Row buffer entry: pair maximum, plus which column won when argmax is on.
`ifdef MAXPOOL_ARGMAX_EN
  localparam int RB_W = DATA_WIDTH + 1;
`else
  localparam int RB_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic signed [DATA_WIDTH-1:0] r_latch;
  logic [RB_W-1:0]              r_rowbuf [POOL_W];
  logic [RB_W-1:0]              r_rb_rd;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;

  logic                         w_out_free;
  logic                         w_accept;
  logic                         w_last_beat;
  logic                         w_pair_col;
  logic                         w_pair_row;
  logic [HW-1:0]                w_half;
  logic signed [DATA_WIDTH-1:0] w_in;
  logic                         w_pair_sel;
  logic signed [DATA_WIDTH-1:0] w_pair_max;
  logic [RB_W-1:0]              w_rb_wdata;
  logic signed [DATA_WIDTH-1:0] w_rb_top;
  logic                         w_bl_gt;
  logic signed [DATA_WIDTH-1:0] w_mid;
  logic                         w_br_gt;
  logic signed [DATA_WIDTH-1:0] w_win;
  logic                         w_window_done;

  // -------------------------------------------------------------------------
  // Handshake helpers
  // -------------------------------------------------------------------------
  assign w_out_free  = !r_out_valid || out_ready_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_last_beat = (r_col == LAST_COL) && (r_row == LAST_ROW);
  assign w_pair_col  = (r_col <= LAST_PAIR_COL);
  assign w_pair_row  = (r_row <= LAST_PAIR_ROW);
  assign w_half      = HW'(r_col >> 1);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_start_i) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_last_beat) w_state_next = S_FLUSH;
      S_FLUSH: if (w_out_free) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o   = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (r_state)
      S_RUN: begin
        in_ready_o = w_out_free;
        busy_o     = 1'b1;
      end
      S_FLUSH: begin
        busy_o       = 1'b1;
        frame_done_o = w_out_free;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && frame_start_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pooling datapath. Tie rule: the later operand wins only if strictly
  // greater, which keeps the lowest window index on ties.
  // -------------------------------------------------------------------------
  assign w_in       = $signed(in_data_i);
  assign w_pair_sel = (w_in > r_latch);
  assign w_pair_max = w_pair_sel ? w_in : r_latch;

`ifdef MAXPOOL_ARGMAX_EN
  assign w_rb_wdata = {w_pair_sel, w_pair_max};
`else
  assign w_rb_wdata = w_pair_max;
`endif

  assign w_rb_top      = $signed(r_rb_rd[DATA_WIDTH-1:0]);
  assign w_bl_gt       = (r_latch > w_rb_top);
  assign w_mid         = w_bl_gt ? r_latch : w_rb_top;
  assign w_br_gt       = (w_in > w_mid);
  assign w_win         = w_br_gt ? w_in : w_mid;
  assign w_window_done = w_accept && r_col[0] && r_row[0] && w_pair_row;

  // Left sample of each horizontal pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_latch <= '0;
    end else if (w_accept && !r_col[0] && w_pair_col && w_pair_row) begin
      r_latch <= w_in;
    end
  end

  // Row buffer with registered read. The entry for a window is fetched on
  // the even-column beat of the odd row, so it is ready for the odd-column
  // beat that completes the window.
  always_ff @(posedge clk_i) begin
    if (w_accept && r_col[0] && !r_row[0] && w_pair_row) begin
      r_rowbuf[w_half] <= w_rb_wdata;
    end
    if (w_accept && !r_col[0] && r_row[0] && w_pair_col && w_pair_row) begin
      r_rb_rd <= r_rowbuf[w_half];
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0] r_out_idx;
  logic [1:0] w_win_idx;
  assign w_win_idx = w_br_gt ? 2'd3 : (w_bl_gt ? 2'd2 : {1'b0, r_rb_rd[DATA_WIDTH]});
  assign out_idx_o = r_out_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_idx <= 2'd0;
    end else if (w_window_done) begin
      r_out_idx <= w_win_idx;
    end
  end
`endif

  // Output register. A completing beat is only accepted when the slot is
  // free or being drained this cycle, so overwriting here never loses data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_window_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_win;
      r_out_last  <= (r_col == LAST_PAIR_COL) && (r_row == LAST_PAIR_ROW);
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
module tb_max_pool_2x2_stream;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fs   [3];
  logic          iv   [3];
  logic          ordy [3];
  logic [DW-1:0] idat [3];
  logic          ir   [3];
  logic          ov   [3];
  logic [DW-1:0] od   [3];
  logic [1:0]    oidx [3];
  logic          ol   [3];
  logic          bz   [3];
  logic          dn   [3];

  max_pool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(26), .IMG_HEIGHT(26)) u_p26 (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs[0]), .in_valid_i(iv[0]),
    .in_ready_o(ir[0]), .in_data_i(idat[0]), .out_valid_o(ov[0]),
    .out_ready_i(ordy[0]), .out_data_o(od[0]),
`ifdef MAXPOOL_ARGMAX_EN
    .out_idx_o(oidx[0]),
`endif
    .out_last_o(ol[0]), .busy_o(bz[0]), .frame_done_o(dn[0]));

  max_pool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_p2 (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs[1]), .in_valid_i(iv[1]),
    .in_ready_o(ir[1]), .in_data_i(idat[1]), .out_valid_o(ov[1]),
    .out_ready_i(ordy[1]), .out_data_o(od[1]),
`ifdef MAXPOOL_ARGMAX_EN
    .out_idx_o(oidx[1]),
`endif
    .out_last_o(ol[1]), .busy_o(bz[1]), .frame_done_o(dn[1]));

  max_pool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_p5 (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs[2]), .in_valid_i(iv[2]),
    .in_ready_o(ir[2]), .in_data_i(idat[2]), .out_valid_o(ov[2]),
    .out_ready_i(ordy[2]), .out_data_o(od[2]),
`ifdef MAXPOOL_ARGMAX_EN
    .out_idx_o(oidx[2]),
`endif
    .out_last_o(ol[2]), .busy_o(bz[2]), .frame_done_o(dn[2]));

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 last;
    logic [1:0]           idx;
  } exp_t;

  typedef struct {
    logic signed [DW-1:0] w [4];
    logic signed [DW-1:0] exp_max;
    logic [1:0]           exp_idx;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] img [0:675];
  exp_t                 exp_q [$];
  logic signed [DW-1:0] got_q [$];
  vec_t                 vecs [7];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  // Reference: direct 2x2 window maximum, ties to the lowest window index.
  task automatic build_model(input int W, input int H);
    exp_t e;
    logic signed [DW-1:0] v [4];
    exp_q.delete();
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        v[0] = img[(2*pr)*W + 2*pc];
        v[1] = img[(2*pr)*W + 2*pc + 1];
        v[2] = img[(2*pr+1)*W + 2*pc];
        v[3] = img[(2*pr+1)*W + 2*pc + 1];
        e.d = v[0];
        e.idx = 2'd0;
        for (int k = 1; k < 4; k++) begin
          if (v[k] > e.d) begin
            e.d = v[k];
            e.idx = 2'(k);
          end
        end
        e.last = (pr == H/2 - 1) && (pc == W/2 - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_ramp(input int W, input int H);
    for (int i = 0; i < W * H; i++) img[i] = DW'(i);
  endtask

  task automatic fill_random(input int W, input int H);
    for (int i = 0; i < W * H; i++) begin
      if ($urandom_range(0, 1) == 1) img[i] = $signed($urandom);
      else img[i] = DW'(int'($urandom_range(0, 8)) - 4);
    end
  endtask

  // mode 0: full rate; mode 1: random valid/ready; mode 2: 10-cycle stall on first output
  task automatic run_frame(input int inst, input int W, input int H, input int mode,
                           input bit use_model, input string tag);
    int beat = 0;
    int cycles = 0;
    int stall_left = 0;
    bit stall_started = 0;
    bit seen_done = 0;
    logic [DW-1:0] held = '0;
    exp_t e;
    if (use_model) build_model(W, H);
    got_q.delete();
    @(negedge clk);
    fs[inst] = 1'b1;
    @(negedge clk);
    fs[inst] = 1'b0;
    #1;
    chk({tag, " busy_after_start"}, longint'(bz[inst]), 1);
    while (!seen_done && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (mode == 2 && !stall_started && ov[inst]) begin
        stall_started = 1;
        stall_left = 10;
        held = od[inst];
      end
      if (mode == 1) ordy[inst] = 1'($urandom_range(0, 1));
      else ordy[inst] = (stall_left > 0) ? 1'b0 : 1'b1;
      if (beat < W * H) begin
        iv[inst] = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        idat[inst] = img[beat];
      end else begin
        iv[inst] = 1'b0;
        idat[inst] = '0;
      end
      #1;
      if (stall_left > 0) begin
        chk({tag, " stall_data"}, longint'(od[inst]), longint'(held));
        chk({tag, " stall_valid"}, longint'(ov[inst]), 1);
        chk({tag, " stall_in_ready"}, longint'(ir[inst]), 0);
        stall_left--;
      end
      if (ov[inst] && ordy[inst]) begin
        if (exp_q.size() == 0) begin
          chk({tag, " extra_output"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " out_data"}, longint'($signed(od[inst])), longint'(e.d));
          chk({tag, " out_last"}, longint'(ol[inst]), longint'(e.last));
`ifdef MAXPOOL_ARGMAX_EN
          chk({tag, " out_idx"}, longint'(oidx[inst]), longint'(e.idx));
`endif
          got_q.push_back($signed(od[inst]));
          $display("OUT %s #%0d data=%0d last=%0d", tag, got_q.size(),
                   $signed(od[inst]), ol[inst]);
        end
      end
      if (iv[inst] && ir[inst]) beat++;
      if (dn[inst]) begin
        seen_done = 1;
        chk({tag, " done_after_beats"}, longint'(beat), longint'(W * H));
        chk({tag, " done_outputs_left"}, longint'(exp_q.size()), 0);
      end
    end
    if (!seen_done) chk({tag, " timeout"}, 0, 1);
    @(negedge clk);
    iv[inst] = 1'b0;
    ordy[inst] = 1'b1;
    #1;
    chk({tag, " done_single_pulse"}, longint'(dn[inst]), 0);
    chk({tag, " idle_after_done"}, longint'(bz[inst]), 0);
    $display("FRAME %s outputs=%0d cycles=%0d", tag, got_q.size(), cycles);
  endtask

  task automatic chk_reset_outputs(input int inst, input string tag);
    chk({tag, " in_ready"}, longint'(ir[inst]), 0);
    chk({tag, " out_valid"}, longint'(ov[inst]), 0);
    chk({tag, " out_data"}, longint'(od[inst]), 0);
    chk({tag, " out_last"}, longint'(ol[inst]), 0);
    chk({tag, " busy"}, longint'(bz[inst]), 0);
    chk({tag, " frame_done"}, longint'(dn[inst]), 0);
`ifdef MAXPOOL_ARGMAX_EN
    chk({tag, " out_idx"}, longint'(oidx[inst]), 0);
`endif
  endtask

  initial begin
    int acc;
    int cyc;
    exp_t e;
    logic signed [DW-1:0] exp5 [4];

    vecs[0].w = '{-5, -3, -9, -4};              vecs[0].exp_max = -3; vecs[0].exp_idx = 2'd1;
    vecs[1].w = '{7, 7, 2, 1};                  vecs[1].exp_max = 7;  vecs[1].exp_idx = 2'd0;
    vecs[2].w = '{1, 2, 3, 9};                  vecs[2].exp_max = 9;  vecs[2].exp_idx = 2'd3;
    vecs[3].w = '{5, 5, 5, 5};                  vecs[3].exp_max = 5;  vecs[3].exp_idx = 2'd0;
    vecs[4].w = '{-1, -1, 0, -1};               vecs[4].exp_max = 0;  vecs[4].exp_idx = 2'd2;
    vecs[5].w = '{32'sh7FFFFFFF, 32'sh80000000, 0, -1};
    vecs[5].exp_max = 32'sh7FFFFFFF; vecs[5].exp_idx = 2'd0;
    vecs[6].w = '{-8, -8, -8, -7};              vecs[6].exp_max = -7; vecs[6].exp_idx = 2'd3;
    exp5 = '{6, 8, 16, 18};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fs[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; idat[i] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) chk_reset_outputs(i, $sformatf("reset_inst%0d", i));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 26x26 ramp at full rate
    fill_ramp(26, 26);
    run_frame(0, 26, 26, 0, 1, "ramp26");
    chk("ramp26 count", longint'(got_q.size()), 169);
    if (got_q.size() == 169) begin
      chk("ramp26 first", longint'(got_q[0]), 27);
      chk("ramp26 final", longint'(got_q[168]), 675);
    end

    // 2x2 single-window vector table
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 4; k++) img[k] = vecs[v].w[k];
      exp_q.delete();
      e.d = vecs[v].exp_max; e.last = 1'b1; e.idx = vecs[v].exp_idx;
      exp_q.push_back(e);
      run_frame(1, 2, 2, 0, 0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d count", v), longint'(got_q.size()), 1);
    end

    // Downstream stall after the first output
    fill_ramp(26, 26);
    run_frame(0, 26, 26, 2, 1, "stall26");
    chk("stall26 count", longint'(got_q.size()), 169);

    // Reset in the middle of a frame, then a clean ramp frame
    fill_random(26, 26);
    @(negedge clk);
    fs[0] = 1'b1;
    @(negedge clk);
    fs[0] = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 1000) begin
      iv[0] = 1'b1;
      idat[0] = img[acc];
      ordy[0] = 1'b1;
      #1;
      if (ir[0]) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("midreset beats_before_reset", longint'(acc), 100);
    iv[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs(0, "midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs(0, "midreset_released");
    fill_ramp(26, 26);
    run_frame(0, 26, 26, 0, 1, "postreset26");
    chk("postreset26 count", longint'(got_q.size()), 169);

    // Odd dimensions: 5x5 ramp
    fill_ramp(5, 5);
    run_frame(2, 5, 5, 0, 1, "ramp5");
    chk("ramp5 count", longint'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("ramp5 val%0d", k), longint'(got_q[k]), longint'(exp5[k]));
    end

    // Randomised frames with random handshakes
    for (int f = 0; f < 3; f++) begin
      fill_random(26, 26);
      run_frame(0, 26, 26, 1, 1, $sformatf("rand26_%0d", f));
    end
    for (int f = 0; f < 4; f++) begin
      fill_random(5, 5);
      run_frame(2, 5, 5, 1, 1, $sformatf("rand5_%0d", f));
    end
    for (int f = 0; f < 6; f++) begin
      fill_random(2, 2);
      run_frame(1, 2, 2, 1, 1, $sformatf("rand2_%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
